// File: rtl/prod_accum_if.sv
// Product-in / sum-out handshake bundle between the multiplier, the accumulator and its consumer.
interface prod_accum_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 18
);
  logic              clear;
  logic [PROD_W-1:0] in_prod;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_cnt;

  modport master (
    output clear, in_prod, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, out_cnt
  );

  modport slave (
    input  clear, in_prod, in_valid, out_ready,
    output in_ready, out_sum, out_valid, out_cnt
  );
endinterface

// File: rtl/prod_accum.sv
// Sums NUM_TERMS unsigned products into one result and holds it on a valid/ready port,
// stalling the product stream until the result is taken.
module prod_accum #(
  parameter int unsigned PROD_W    = 16,
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned ACC_W     = 18
) (
  input  logic      clk,
  input  logic      reset,
  prod_accum_if.slave bus
);

  localparam int unsigned EXT_W = ACC_W - PROD_W;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic               out_valid_q;
  logic [7:0]         cnt_q;
  logic [ACC_W-1:0]   sum_d;
  logic               in_ready_c;
  logic               accept_c;
  logic               last_c;

  assign in_ready_c = (state_q == ST_ACCUM) && !bus.clear && !reset;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign last_c     = (cnt_q == 8'(NUM_TERMS - 1));
  assign sum_d      = acc_q + {{EXT_W{1'b0}}, bus.in_prod};

  // Reset and clear flush everything, including a result still waiting in HOLD.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            if (last_c) begin
              out_sum_q   <= sum_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: stimulus pushes expected sums, a monitor pops them on each output transfer.
module tb_prod_accum;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  bit   done;
  logic [17:0] exp_q[$];

  prod_accum_if #(.PROD_W(16), .ACC_W(18)) bus ();

  prod_accum #(.PROD_W(16), .NUM_TERMS(4), .ACC_W(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] p);
    bus.in_valid = v;
    bus.in_prod  = p;
    step();
  endtask

  task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    drive(1'b1, a);
    drive(1'b1, b);
    drive(1'b1, c);
    drive(1'b1, d);
    bus.in_valid = 1'b0;
  endtask

  task automatic stimulus();
    // reset state
    repeat (3) step();
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_cnt", int'(bus.out_cnt), 0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", int'(bus.in_ready), 1);

    // 10+20+30+40 with out_cnt stepping
    bus.out_ready = 1'b1;
    exp_q.push_back(18'd100);
    chk("t1_cnt0", int'(bus.out_cnt), 0);
    drive(1'b1, 16'd10); chk("t1_cnt1", int'(bus.out_cnt), 1);
    drive(1'b1, 16'd20); chk("t1_cnt2", int'(bus.out_cnt), 2);
    drive(1'b1, 16'd30); chk("t1_cnt3", int'(bus.out_cnt), 3);
    drive(1'b1, 16'd40);
    bus.in_valid = 1'b0;
    chk("t1_valid", int'(bus.out_valid), 1);
    chk("t1_cnt_hold", int'(bus.out_cnt), 0);
    chk("t1_sum", int'(bus.out_sum), 100);
    step();
    chk("t1_valid_one_cycle", int'(bus.out_valid), 0);

    // worst-case products, no wrap
    exp_q.push_back(18'h3F804);
    feed4(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
    chk("t2_sum", int'(bus.out_sum), 260100);
    step();

    // back-pressure: 7s offered during HOLD must not count
    bus.out_ready = 1'b0;
    exp_q.push_back(18'd8);
    exp_q.push_back(18'd28);
    feed4(16'd2, 16'd2, 16'd2, 16'd2);
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_in_ready", int'(bus.in_ready), 0);
      chk("t3_hold_sum", int'(bus.out_sum), 8);
      chk("t3_hold_valid", int'(bus.out_valid), 1);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_released_valid", int'(bus.out_valid), 0);
    chk("t3_released_cnt", int'(bus.out_cnt), 0);
    repeat (4) step();
    bus.in_valid = 1'b0;
    chk("t3_sum28", int'(bus.out_sum), 28);
    step();

    // in_valid gaps
    exp_q.push_back(18'd10);
    drive(1'b1, 16'd1);
    drive(1'b0, 16'd99);
    drive(1'b0, 16'd99);
    drive(1'b1, 16'd2);
    drive(1'b0, 16'd99);
    drive(1'b1, 16'd3);
    chk("t4_not_yet", int'(bus.out_valid), 0);
    drive(1'b1, 16'd4);
    bus.in_valid = 1'b0;
    chk("t4_valid", int'(bus.out_valid), 1);
    chk("t4_sum", int'(bus.out_sum), 10);
    step();

    // clear mid-accumulation drops partial sum and the product of the clear cycle
    exp_q.push_back(18'd4);
    drive(1'b1, 16'd5);
    drive(1'b1, 16'd6);
    chk("t5_cnt2", int'(bus.out_cnt), 2);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd9;
    #1;
    chk("t5_clear_in_ready", int'(bus.in_ready), 0);
    step();
    bus.clear = 1'b0;
    chk("t5_cnt_after_clear", int'(bus.out_cnt), 0);
    feed4(16'd1, 16'd1, 16'd1, 16'd1);
    chk("t5_sum", int'(bus.out_sum), 4);
    step();

    // clear in HOLD discards result even with out_ready high
    bus.out_ready = 1'b0;
    feed4(16'd5, 16'd5, 16'd5, 16'd5);
    chk("t6_hold_sum", int'(bus.out_sum), 20);
    bus.out_ready = 1'b1;
    bus.clear     = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("t6_clear_valid", int'(bus.out_valid), 0);
    chk("t6_clear_sum", int'(bus.out_sum), 0);

    // reset in HOLD
    bus.out_ready = 1'b0;
    feed4(16'd3, 16'd3, 16'd3, 16'd3);
    chk("t7_hold_valid", int'(bus.out_valid), 1);
    chk("t7_hold_sum", int'(bus.out_sum), 12);
    reset = 1'b1;
    step();
    chk("t7_rst_valid", int'(bus.out_valid), 0);
    chk("t7_rst_sum", int'(bus.out_sum), 0);
    reset = 1'b0;
    #1;
    chk("t7_rel_in_ready", int'(bus.in_ready), 1);

    // fresh sum after reset
    bus.out_ready = 1'b1;
    exp_q.push_back(18'd10);
    feed4(16'd1, 16'd2, 16'd3, 16'd4);
    chk("t8_sum", int'(bus.out_sum), 10);
    repeat (3) step();
    done = 1'b1;
  endtask

  task automatic monitor();
    logic [17:0] exp;
    while (!done) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && !reset && !bus.clear) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got result %0d expected no result at %0t", bus.out_sum, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("sb_out_sum", int'(bus.out_sum), int'(exp));
        end
      end
    end
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    done          = 1'b0;
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    fork
      stimulus();
      monitor();
    join
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
